// File: rtl/vis_stream_serialiser_if.sv
// Handshake bundle around the serialiser: 2*ACCUM-bit visibility stream in, byte stream out.
interface vis_stream_serialiser_if #(
    parameter int ACCUM = 32
);
    logic [ACCUM-1:0] s_revis_i;
    logic [ACCUM-1:0] s_imvis_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic             s_last_i;
    logic [7:0]       m_tdata_o;
    logic             m_tvalid_o;
    logic             m_tready_i;
    logic             m_tlast_o;

    modport slave (
        input  s_revis_i, s_imvis_i, s_valid_i, s_last_i, m_tready_i,
        output s_ready_o, m_tdata_o, m_tvalid_o, m_tlast_o
    );

    modport master (
        output s_revis_i, s_imvis_i, s_valid_i, s_last_i, m_tready_i,
        input  s_ready_o, m_tdata_o, m_tvalid_o, m_tlast_o
    );
endinterface

// File: rtl/vis_stream_serialiser.sv
// Serialises visibility frames into bytes: 4-byte header (sync, sequence) then
// revis/imvis bytes LSB first; one word plus one output byte of storage.
module vis_stream_serialiser #(
    parameter int          ACCUM   = 32,
    parameter logic [15:0] SYNC    = 16'h5AA5,
    parameter int          SEQBITS = 16
) (
    input  logic               bus_clock,
    input  logic               bus_rst_n,
    vis_stream_serialiser_if.slave bus,
    output logic [SEQBITS-1:0] frame_count_o
);
    localparam int NB = ACCUM / 4;
    localparam int IW = (NB > 4) ? $clog2(NB) : 2;
    localparam logic [IW-1:0] HDR_LAST  = IW'(3);
    localparam logic [IW-1:0] DATA_LAST = IW'(NB - 1);

    typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [SEQBITS-1:0] seq;
    logic [SEQBITS-1:0] frame_cnt;
    logic [2*ACCUM-1:0] word;
    logic               cur_last;
    logic [7:0]         tdata;
    logic               tvalid;
    logic               tlast;

    logic               adv;
    logic               slot;
    logic               pending;
    logic               ready;
    logic               accept;
    logic [IW-1:0]      nxt_idx;
    logic [7:0]         hdr_byte;
    logic [7:0]         data_byte;

    assign adv     = !tvalid || bus.m_tready_i;
    assign slot    = tvalid && ((state == HEAD && idx == HDR_LAST) ||
                                (state == DATA && idx == DATA_LAST));
    // Output went empty at an accept slot with no word available.
    assign pending = !tvalid && (state != IDLE);
    assign ready   = (state != IDLE) && !cur_last && ((adv && slot) || pending);
    assign accept  = ready && bus.s_valid_i;
    assign nxt_idx = idx + 1'b1;

    always_comb begin
        hdr_byte = SYNC[7:0];
        case (nxt_idx[1:0])
            2'd1:    hdr_byte = SYNC[15:8];
            2'd2:    hdr_byte = seq[7:0];
            2'd3:    hdr_byte = seq[15:8];
            default: hdr_byte = SYNC[7:0];
        endcase
    end

    assign data_byte = 8'(word >> {nxt_idx, 3'b000});

    always_ff @(posedge bus_clock or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            seq       <= '0;
            frame_cnt <= '0;
            word      <= '0;
            cur_last  <= 1'b0;
            tdata     <= 8'h00;
            tvalid    <= 1'b0;
            tlast     <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                word     <= {bus.s_imvis_i, bus.s_revis_i};
                cur_last <= bus.s_last_i;
                idx      <= '0;
                state    <= DATA;
                tdata    <= bus.s_revis_i[7:0];
                tvalid   <= 1'b1;
                tlast    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tlast <= 1'b0;
                        if (bus.s_valid_i) begin
                            tdata    <= SYNC[7:0];
                            tvalid   <= 1'b1;
                            idx      <= '0;
                            cur_last <= 1'b0;
                            state    <= HEAD;
                        end else begin
                            tvalid <= 1'b0;
                        end
                    end
                    HEAD: begin
                        if (tvalid) begin
                            if (idx == HDR_LAST) begin
                                tvalid <= 1'b0;
                            end else begin
                                idx   <= nxt_idx;
                                tdata <= hdr_byte;
                            end
                        end
                    end
                    DATA: begin
                        if (tvalid) begin
                            if (idx == DATA_LAST) begin
                                tvalid <= 1'b0;
                                tlast  <= 1'b0;
                                if (cur_last) begin
                                    seq       <= seq + 1'b1;
                                    frame_cnt <= seq + 1'b1;
                                    cur_last  <= 1'b0;
                                    state     <= IDLE;
                                end
                            end else begin
                                idx   <= nxt_idx;
                                tdata <= data_byte;
                                tlast <= cur_last && (nxt_idx == DATA_LAST);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.s_ready_o  = ready;
    assign bus.m_tdata_o  = tdata;
    assign bus.m_tvalid_o = tvalid;
    assign bus.m_tlast_o  = tlast;
    assign frame_count_o  = frame_cnt;
endmodule
